alu_muldiv: RTL and testbench

Parametrised next-generation ALU for the MIPS datapath.
- Keeps the single-cycle combinational ops: ADD, SUB, AND, OR, SLT, NOR. Adds XOR, SLTU, signed overflow, and HI/LO readback.
- Adds a multi-cycle shift-add multiplier and restoring divider, signed and unsigned, that write internal HI/LO registers.
- A start/busy/done handshake lets the control unit stall the pipeline during multiply/divide.

---
 rtl/alu_muldiv.sv | 209 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// MIPS ALU: single-cycle combinational ops plus a multi-cycle shift-add multiplier
// and restoring divider (signed/unsigned) writing HI/LO, with a start/busy/done handshake.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       ALUControl,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Combinational datapath
  logic [WIDTH-1:0] sum, diff;
  logic             slt, sltu;

  assign sum  = input1 + input2;
  assign diff = input1 - input2;
  assign slt  = $signed(input1) < $signed(input2);
  assign sltu = input1 < input2;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        result   = sum;
        overflow = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_AND:  result = input1 & input2;
      OP_OR:   result = input1 | input2;
      OP_NOR:  result = ~(input1 | input2);
      OP_XOR:  result = input1 ^ input2;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, sltu};
      OP_MFHI: result = hi_q;
      OP_MFLO: result = lo_q;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Launch decode: signed ops iterate on magnitudes and fix the sign afterwards
  logic             is_mc, op_signed, op_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mc     = ALUControl inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign op_signed = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
  assign op_div    = (ALUControl == OP_DIV) || (ALUControl == OP_DIVU);
  assign a_mag     = (op_signed && input1[WIDTH-1]) ? -input1 : input1;
  assign b_mag     = (op_signed && input2[WIDTH-1]) ? -input2 : input2;

  // Multiply step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits becoming quotient}
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic               unused_div_msb;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh         = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff       = {1'b0, rem_sh} - {2'b00, b_q};
  assign div_ok         = ~div_diff[WIDTH+1];
  assign unused_div_msb = div_diff[WIDTH];
  assign div_next       = div_ok ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                 : {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start && is_mc) begin
          state_d   = RUN;
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
          b_d       = op_div ? b_mag : a_mag;
          a_d       = input1;
          is_div_d  = op_div;
          neg_res_d = op_signed && (input1[WIDTH-1] ^ input2[WIDTH-1]);
          neg_rem_d = op_signed && input1[WIDTH-1];
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
          // Divide by zero reports the raw dividend, not its magnitude
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] input1, input2;
  logic [3:0]   ALUControl;
  logic         start;
  logic [W-1:0] result, hi, lo;
  logic         zero, overflow, busy, done;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .input1(input1), .input2(input2),
    .ALUControl(ALUControl), .start(start), .result(result), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_mc(input logic [3:0] op);
    return op == 4'b1010 || op == 4'b1011 || op == 4'b1101 || op == 4'b1110;
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1100: return ~(a | b);
      4'b0011: return a ^ b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: return (a < b) ? 1 : 0;
      4'b0100: return m_hi;
      4'b0101: return m_lo;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    longint lim;
    lim = 64'h0000_0000_8000_0000;
    if (op == 4'b0010)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'b0110) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s >= lim) || (s < -lim);
  endfunction

  function automatic void ref_muldiv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    p = '0;
    h = '0;
    l = '0;
    case (op)
      4'b1010: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
      4'b1011: begin p = {32'b0, a} * {32'b0, b};     h = p[63:32]; l = p[31:0]; end
      4'b1101: begin
        if (b == 0) begin l = '1; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = '0; end
        else begin l = sa / sb; h = sa % sb; end
      end
      4'b1110: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'($urandom_range(0, 15));
      4:       return ~32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    ALUControl = op;
    input1 = a;
    input2 = b;
    #1;
    er = ref_result(op, a, b);
    check($sformatf("result op=%b", op), result, er);
    check($sformatf("zero op=%b", op), zero, er == 0);
    check($sformatf("overflow op=%b", op), overflow, ref_ovf(op, a, b));
  endtask

  // Launch an op (start seen at the next edge), exercise combinational ops while busy,
  // optionally pulse a stray start at cycle inj, and check the done cycle.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    logic [W-1:0] eh, el;
    logic [3:0]   cop;
    ref_muldiv(op, a, b, eh, el);
    ALUControl = op;
    input1 = a;
    input2 = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy after edge 0", busy, 1);
    check("done after edge 0", done, 0);
    for (int k = 1; k <= W; k++) begin
      cop = 4'($urandom);
      if (k == inj) begin
        cop = 4'b1110;
        start = 1'b1;
      end
      check_comb(cop, rnd_opnd(), rnd_opnd());
      tick();
      start = 1'b0;
      check($sformatf("busy edge %0d", k), busy, 1);
      check($sformatf("done edge %0d", k), done, 0);
      check($sformatf("hi hold edge %0d", k), hi, m_hi);
      check($sformatf("lo hold edge %0d", k), lo, m_lo);
    end
    tick();
    m_hi = eh;
    m_lo = el;
    check("busy at done", busy, 0);
    check("done pulse", done, 1);
    check($sformatf("hi op=%b a=%h b=%h", op, a, b), hi, eh);
    check($sformatf("lo op=%b a=%h b=%h", op, a, b), lo, el);
    check_comb(4'b0101, rnd_opnd(), rnd_opnd());
  endtask

  task automatic idle_cycles(input int n);
    logic [3:0] cop;
    for (int i = 0; i < n; i++) begin
      do cop = 4'($urandom); while (is_mc(cop));
      start = 1'($urandom);
      check_comb(cop, rnd_opnd(), rnd_opnd());
      tick();
      start = 1'b0;
      check("idle busy", busy, 0);
      check("idle done", done, 0);
      check("idle hi", hi, m_hi);
      check("idle lo", lo, m_lo);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ALUControl = 4'b0000;
    input1 = '0;
    input2 = '0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    tick();
    tick();
    reset = 1'b0;

    check_comb(4'b0010, 32'h7FFF_FFFF, 32'h1);
    check("add max+1", result, 32'h8000_0000);
    check("add ovf", overflow, 1);
    check_comb(4'b0110, 32'd5, 32'd5);
    check("sub zero", zero, 1);
    check_comb(4'b0111, 32'hFFFF_FFFF, 32'd1);
    check("slt -1<1", result, 1);
    check_comb(4'b1000, 32'hFFFF_FFFF, 32'd1);
    check("sltu max<1", result, 0);
    check_comb(4'b0110, 32'h8000_0000, 32'd1);
    check_comb(4'b1111, 32'h1234, 32'h5678);
    for (int i = 0; i < 200; i++) check_comb(4'($urandom), rnd_opnd(), rnd_opnd());

    run_op(4'b1010, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult -3x7 hi", hi, 32'hFFFF_FFFF);
    check("mult -3x7 lo", lo, 32'hFFFF_FFEB);
    idle_cycles(2);
    run_op(4'b1110, 32'd100, 32'd7, 0);
    check("divu 100/7 lo", lo, 32'd14);
    run_op(4'b1101, 32'hFFFF_FFF9, 32'd2, 0);
    check("div -7/2 hi", hi, 32'hFFFF_FFFF);
    run_op(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div minneg/-1 lo", lo, 32'h8000_0000);
    run_op(4'b1110, 32'h1234, 32'd0, 0);
    check("divu by 0 hi", hi, 32'h1234);
    run_op(4'b1101, 32'hFFFF_FF00, 32'd0, 0);
    idle_cycles(1);
    run_op(4'b1011, 32'd2, 32'd3, 10);
    check("multu ignored start lo", lo, 32'd6);
    run_op(4'b1110, 32'd9, 32'd3, 0);
    check("back-to-back divu lo", lo, 32'd3);
    idle_cycles(1);

    ALUControl = 4'b1011;
    input1 = 32'hFFFF_FFFF;
    input2 = 32'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("midop reset busy", busy, 0);
    check("midop reset done", done, 0);
    check("midop reset hi", hi, 0);
    check("midop reset lo", lo, 0);
    tick();
    reset = 1'b0;
    idle_cycles(W + 4);
    run_op(4'b1011, 32'hFFFF_FFFF, 32'd2, 0);

    for (int i = 0; i < 30; i++) begin
      logic [3:0] mop;
      case ($urandom_range(0, 3))
        0:       mop = 4'b1010;
        1:       mop = 4'b1011;
        2:       mop = 4'b1101;
        default: mop = 4'b1110;
      endcase
      run_op(mop, rnd_opnd(), rnd_opnd(), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, W)));
      if ($urandom_range(0, 1) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
